// File: rtl/alu_writeback.sv
// Writeback stage between the Rapids ALU and the register-file write port:
// buffers results in a small FIFO, retires Y1 then optional Y2, owns the compare flags.
// Optional same-cycle Y1 bypass on an empty FIFO is enabled by defining ALU_WB_BYPASS_EN.
module alu_writeback #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_y1,
  input  logic [DATA_W-1:0] in_y2,
  input  logic [ADDR_W-1:0] in_dst1,
  input  logic [ADDR_W-1:0] in_dst2,
  input  logic              in_wr2,
  input  logic [7:0]        in_cmp,
  input  logic              in_cmp_we,
  input  logic              rf_stall,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [7:0]        flags,
  output logic              busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] y1;
    logic [DATA_W-1:0] y2;
    logic [ADDR_W-1:0] dst1;
    logic [ADDR_W-1:0] dst2;
    logic              wr2;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR1  = 2'd1,
    WR2  = 2'd2
  } state_t;

  entry_t        mem_q [DEPTH];
  logic [PW-1:0] wptr_q;
  logic [PW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  state_t        state_q;
  state_t        state_d;
  state_t        cur_state;
  logic [7:0]    flags_q;

  logic   empty;
  logic   full;
  logic   accept;
  logic   bypass;
  logic   push;
  logic   pop;
  entry_t head;
  entry_t in_entry;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign in_ready = !rst && !full;
  assign accept   = in_valid && in_ready;
  assign head     = mem_q[rptr_q];
  assign busy     = !rst && !empty;
  assign flags    = flags_q;

  assign in_entry.y1   = in_y1;
  assign in_entry.y2   = in_y2;
  assign in_entry.dst1 = in_dst1;
  assign in_entry.dst2 = in_dst2;
  assign in_entry.wr2  = in_wr2;

`ifdef ALU_WB_BYPASS_EN
  // A lone Y1 write skips the FIFO when nothing is queued ahead of it.
  assign bypass = empty && in_valid && !in_wr2 && !rf_stall && !rst;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && !bypass;

  // IDLE with a non-empty FIFO presents the head immediately, as WR1.
  always_comb begin
    cur_state = state_q;
    if (state_q == IDLE && !empty) begin
      cur_state = WR1;
    end
  end

  always_comb begin
    state_d  = cur_state;
    rf_we    = 1'b0;
    rf_waddr = head.dst1;
    rf_wdata = head.y1;
    pop      = 1'b0;
    count_d  = count_q;

    case (cur_state)
      IDLE: begin
        state_d = IDLE;
        if (bypass) begin
          rf_we    = 1'b1;
          rf_waddr = in_dst1;
          rf_wdata = in_y1;
        end
      end
      WR1: begin
        rf_we = !rf_stall;
        if (!rf_stall) begin
          if (head.wr2) begin
            state_d = WR2;
          end else begin
            pop = 1'b1;
          end
        end
      end
      WR2: begin
        rf_we    = !rf_stall;
        rf_waddr = head.dst2;
        rf_wdata = head.y2;
        if (!rf_stall) begin
          pop = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end

    if (pop) begin
      state_d = (count_d != '0) ? WR1 : IDLE;
    end

    if (rst) begin
      rf_we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) begin
        wptr_q <= wptr_q + 1'b1;
      end
      if (pop) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (accept && in_cmp_we) begin
        flags_q <= in_cmp;
      end
    end
  end

  // Payload storage needs no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= in_entry;
    end
  end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Execute-to-register-file writeback stage sitting directly downstream of the Rapids ALU.
- Accepts a two-word ALU result (Y1, Y2), destination indices and compare result through a valid/ready handshake, and buffers it in a small FIFO.
- Retires each result through the register file's single write port: Y1 first, then Y2 when requested.
- Holds the architectural compare-flags register.

Parameters:
- DATA_W, 32, width of Y1/Y2 and of the write-port data
- ADDR_W, 5, register index width
- DEPTH, 2, result FIFO entries; power of two, at least 2

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  ALU result valid
- in_ready  output  1  stage can accept; equals FIFO not full
- in_y1  input  DATA_W  ALU Y1
- in_y2  input  DATA_W  ALU Y2
- in_dst1  input  ADDR_W  destination for Y1
- in_dst2  input  ADDR_W  destination for Y2
- in_wr2  input  1  Y2 is also written (DOUBLE or dual-lane ops)
- in_cmp  input  8  ALU compare_res
- in_cmp_we  input  1  update flags with in_cmp
- rf_stall  input  1  write port unavailable this cycle
- rf_we  output  1  register-file write enable
- rf_waddr  output  ADDR_W  write address
- rf_wdata  output  DATA_W  write data
- flags  output  8  architectural compare flags
- busy  output  1  FIFO non-empty or a write is in progress

Behaviour:
- Reset (rst=1 at posedge): FIFO empty, FSM in IDLE, flags=0. While rst is high: rf_we=0, in_ready=0, busy=0. Reset mid-retire drops all buffered entries; no partial Y2 write follows.
- Accept: an entry is pushed when in_valid and in_ready are both high at a posedge. Each entry stores y1, y2, dst1, dst2, wr2.
- Flags: when in_cmp_we is high, flags <= in_cmp at the accept edge. Flags therefore follow acceptance order, not write order.
- Handshake: in_ready is a function of FIFO occupancy only; it must not depend on in_valid. When the FIFO is full, in_ready is low and input data is ignored.
- FSM, combinational outputs from the registered state plus the FIFO head:
  - IDLE: the FIFO is empty, or the head has not yet been presented. A non-empty FIFO moves to WR1 on the same cycle.
  - WR1: rf_we=!rf_stall, rf_waddr=head.dst1, rf_wdata=head.y1.
    - On !rf_stall with head.wr2=1, go to WR2.
    - On !rf_stall with head.wr2=0, pop the head and go to WR1 if the FIFO still holds an entry, else IDLE.
    - On rf_stall, stay in WR1.
  - WR2: rf_we=!rf_stall, rf_waddr=head.dst2, rf_wdata=head.y2.
    - On !rf_stall, pop the head and go to WR1 or IDLE as above.
    - On rf_stall, hold.
- Latency: a result accepted at edge N drives its Y1 write during cycle N+1 at the earliest, and its Y2 write during N+2.
- Throughput: one register write per unstalled cycle; back-to-back single-write entries retire one per cycle.
- Simultaneous push and pop on a full FIFO: a pop frees the slot only from the following cycle, since in_ready is registered-occupancy based. Push and pop in the same cycle on a non-full FIFO are both honoured; the count is unchanged.
- Pointers wrap modulo DEPTH. The count saturates at 0 and DEPTH by construction and never overflows.
- dst1 equal to dst2 with wr2=1: both writes are issued, and Y2 is the final value.
- busy = (count != 0).

Optional Feature:
- Macro ALU_WB_BYPASS_EN.
- Defined: when the FIFO is empty, in_valid=1, in_wr2=0 and rf_stall=0, the Y1 write is issued combinationally in the same cycle (rf_we=1, rf_waddr=in_dst1, rf_wdata=in_y1). The entry is not pushed, and flags update as normal. in_ready stays 1.
- Not defined: all results go through the FIFO, with a minimum 1-cycle latency.

Test Plan:
- Single write: rst, then push y1=0x12345678, dst1=3, wr2=0 -> one cycle later rf_we=1, waddr=3, wdata=0x12345678; the next cycle rf_we=0 and busy=0.
- Double write: push y1=0xAAAA0000, y2=0x0000BBBB, dst1=4, dst2=5, wr2=1 -> consecutive writes (4, 0xAAAA0000) then (5, 0x0000BBBB).
- Stall in WR2: double entry with rf_stall=1 for 3 cycles starting at the Y2 write -> waddr=5 is held stable for 3 cycles with rf_we=0, then written once.
- Full back-pressure: rf_stall=1, push 2 entries -> in_ready=0. A third in_valid with dst1=7 is not accepted. Release the stall -> entries retire in order, and dst1=7 is accepted only after in_ready rises.
- Flags and reset: push with in_cmp=0x5A and in_cmp_we=1 -> flags=0x5A after the edge. Assert rst during WR1 of a double entry -> flags=0, rf_we=0, and no later write to dst2.
- Bypass, only with ALU_WB_BYPASS_EN: empty FIFO, push y1=0x1, dst1=9, wr2=0 -> rf_we=1, waddr=9 in the same cycle, and busy stays 0.
